// File: rtl/strhw_common_types.sv
// Types shared between the strhw message sequencer, its block packer and the compression stage.
package strhw_common_types;

    typedef logic [511:0] uint512;
    typedef logic [6:0]   uint7;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned BLOCK_SIZE = 64;
    localparam int unsigned BEAT_BYTES = 8;

    // 256-bit digest variant starts from an IV of all 8'h01 bytes
    localparam uint512 IV_256 = {64{8'h01}};

    typedef enum logic {
        MODE_512 = 1'b0,
        MODE_256 = 1'b1
    } digest_mode_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FILL      = 3'd1,
        S_TRG       = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_OUT       = 3'd5
    } seq_state_t;

    function automatic uint512 iv_of(input digest_mode_t m);
        return (m == MODE_256) ? IV_256 : '0;
    endfunction

    // 256-bit digest is the upper half of h, returned in the low half of the bus
    function automatic uint512 digest_of(input digest_mode_t m, input uint512 h);
        return (m == MODE_256) ? {256'h0, h[511:256]} : h;
    endfunction

endpackage

// File: rtl/strhw_block_packer.sv
// Accumulates 64-bit byte-lane beats into a 512-bit little-endian block buffer.
module strhw_block_packer
    import strhw_common_types::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        beat_en_i,
    input  logic [63:0] data_i,
    input  logic [3:0]  bytes_i,
    output uint512      block_o,
    output uint7        fill_o
);

    localparam int unsigned LANES = 8;

    uint512      block_q;
    uint512      block_d;
    uint7        fill_q;
    uint7        fill_d;
    logic [63:0] beat_c;

    // Lanes at or above the valid byte count never reach the buffer
    always_comb begin
        beat_c = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            if (4'(j) < bytes_i) begin
                beat_c[j*8 +: 8] = data_i[j*8 +: 8];
            end
        end
    end

    always_comb begin
        block_d = block_q;
        fill_d  = fill_q;
        if (clear_i) begin
            block_d = '0;
            fill_d  = '0;
        end else if (beat_en_i && !fill_q[6]) begin
            block_d[{fill_q[5:3], 6'd0} +: 64] = beat_c;
            fill_d = fill_q + 7'(bytes_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            block_q <= '0;
            fill_q  <= '0;
        end else begin
            block_q <= block_d;
            fill_q  <= fill_d;
        end
    end

    assign block_o = block_q;
    assign fill_o  = fill_q;

endmodule

// File: rtl/strhw_msg_sequencer.sv
// Packs a byte-lane beat stream into 512-bit blocks, hands them to strhw_stage one at a time and
// keeps the running h/N/Sigma chaining values until the final digest is produced.
module strhw_msg_sequencer
    import strhw_common_types::*;
#(
    parameter logic [15:0] STG_TIMEOUT = 16'hFFFF
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         mode_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [63:0]  in_data_i,
    input  logic [3:0]   in_bytes_i,
    input  logic         in_last_i,
    output logic         stg_trg_o,
    output uint512       stg_block_o,
    output uint7         stg_block_size_o,
    output uint512       stg_h_o,
    output uint512       stg_n_o,
    output uint512       stg_sigma_o,
    input  uint512       stg_h_new_i,
    input  uint512       stg_n_new_i,
    input  uint512       stg_sigma_new_i,
    input  state_t       stg_state_i,
    output uint512       digest_o,
    output logic         digest_valid_o,
    output logic         busy_o,
    output logic         err_o
);

    localparam int unsigned TMO_W = 16;

    seq_state_t   state_q, state_d;
    digest_mode_t mode_q, mode_d;
    logic         fin_q, fin_d;
    logic         tail_q, tail_d;
    uint7         size_q, size_d;
    uint512       h_q, h_d;
    uint512       n_q, n_d;
    uint512       sigma_q, sigma_d;
    uint512       digest_q, digest_d;
    logic         dv_q, dv_d;
    logic         busy_q, busy_d;
    logic         err_q, err_d;
    logic         trg_q, trg_d;
    logic         ready_q, ready_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic         accept_c;
    logic         beat_err_c;
    logic [3:0]   eff_bytes_c;
    uint7         fill_w;
    uint7         fill_next_c;
    logic         pk_clear_c;
    logic         tmo_hit_c;

    // Malformed beats flag an error and are taken as a full 8-byte beat
    always_comb begin
        accept_c    = in_valid_i && ready_q;
        beat_err_c  = (in_bytes_i > 4'(BEAT_BYTES)) ||
                      (!in_last_i && (in_bytes_i != 4'(BEAT_BYTES)));
        eff_bytes_c = beat_err_c ? 4'(BEAT_BYTES) : in_bytes_i;
        fill_next_c = fill_w + 7'(eff_bytes_c);
        tmo_hit_c   = (STG_TIMEOUT != 16'd0) && (tmo_q == STG_TIMEOUT - 16'd1);
    end

    strhw_block_packer u_packer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (pk_clear_c),
        .beat_en_i (accept_c),
        .data_i    (in_data_i),
        .bytes_i   (eff_bytes_c),
        .block_o   (stg_block_o),
        .fill_o    (fill_w)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        fin_d      = fin_q;
        tail_d     = tail_q;
        size_d     = size_q;
        h_d        = h_q;
        n_d        = n_q;
        sigma_d    = sigma_q;
        digest_d   = digest_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        pk_clear_c = 1'b0;

        case (state_q)
            S_IDLE, S_FILL: begin
                if (accept_c) begin
                    if (state_q == S_IDLE) begin
                        mode_d  = digest_mode_t'(mode_i);
                        h_d     = iv_of(digest_mode_t'(mode_i));
                        n_d     = '0;
                        sigma_d = '0;
                    end
                    err_d = err_q | beat_err_c;
                    // A full last block still needs the mandatory size-0 final block after it
                    if (fill_next_c == 7'(BLOCK_SIZE)) begin
                        state_d = S_TRG;
                        size_d  = fill_next_c;
                        fin_d   = 1'b0;
                        tail_d  = in_last_i;
                    end else if (in_last_i) begin
                        state_d = S_TRG;
                        size_d  = fill_next_c;
                        fin_d   = 1'b1;
                        tail_d  = 1'b0;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_TRG: begin
                state_d = S_WAIT_BUSY;
                tmo_d   = '0;
            end
            S_WAIT_BUSY: begin
                if (stg_state_i == BUSY) begin
                    state_d = S_WAIT_DONE;
                    tmo_d   = tmo_q + 16'd1;
                end else if (tmo_hit_c) begin
                    state_d    = S_IDLE;
                    err_d      = 1'b1;
                    fin_d      = 1'b0;
                    tail_d     = 1'b0;
                    pk_clear_c = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_WAIT_DONE: begin
                if (stg_state_i == DONE) begin
                    h_d        = stg_h_new_i;
                    n_d        = stg_n_new_i;
                    sigma_d    = stg_sigma_new_i;
                    pk_clear_c = 1'b1;
                    if (fin_q) begin
                        state_d  = S_OUT;
                        digest_d = digest_of(mode_q, stg_h_new_i);
                    end else if (tail_q) begin
                        state_d = S_TRG;
                        size_d  = '0;
                        fin_d   = 1'b1;
                        tail_d  = 1'b0;
                    end else begin
                        state_d = S_FILL;
                    end
                end else if (tmo_hit_c) begin
                    state_d    = S_IDLE;
                    err_d      = 1'b1;
                    fin_d      = 1'b0;
                    tail_d     = 1'b0;
                    pk_clear_c = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                pk_clear_c = 1'b1;
            end
        endcase

        // Handshake and status outputs are registered images of the next state
        ready_d = (state_d == S_IDLE) || (state_d == S_FILL);
        trg_d   = (state_d == S_TRG);
        dv_d    = (state_d == S_OUT);
        busy_d  = (state_d == S_FILL) || (state_d == S_TRG) ||
                  (state_d == S_WAIT_BUSY) || (state_d == S_WAIT_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            mode_q   <= MODE_512;
            fin_q    <= 1'b0;
            tail_q   <= 1'b0;
            size_q   <= '0;
            h_q      <= '0;
            n_q      <= '0;
            sigma_q  <= '0;
            digest_q <= '0;
            dv_q     <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            trg_q    <= 1'b0;
            ready_q  <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            fin_q    <= fin_d;
            tail_q   <= tail_d;
            size_q   <= size_d;
            h_q      <= h_d;
            n_q      <= n_d;
            sigma_q  <= sigma_d;
            digest_q <= digest_d;
            dv_q     <= dv_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            trg_q    <= trg_d;
            ready_q  <= ready_d;
            tmo_q    <= tmo_d;
        end
    end

    assign in_ready_o       = ready_q;
    assign stg_trg_o        = trg_q;
    assign stg_block_size_o = size_q;
    assign stg_h_o          = h_q;
    assign stg_n_o          = n_q;
    assign stg_sigma_o      = sigma_q;
    assign digest_o         = digest_q;
    assign digest_valid_o   = dv_q;
    assign busy_o           = busy_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_strhw_msg_sequencer.sv
// Directed bench for strhw_msg_sequencer with a stub compression stage and a trigger/digest scoreboard.
module tb_strhw_msg_sequencer;
    import strhw_common_types::*;

    typedef struct {
        logic [6:0]   size;
        logic [511:0] blk;
        logic [511:0] h;
        logic [511:0] n;
        logic [511:0] sigma;
    } trg_exp_t;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         mode = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [63:0]  in_data = '0;
    logic [3:0]   in_bytes = '0;
    logic         in_last = 1'b0;
    logic         stg_trg;
    uint512       stg_block;
    uint7         stg_size;
    uint512       stg_h, stg_n, stg_sigma;
    uint512       h_new = '0, n_new = '0, sigma_new = '0;
    state_t       stub_st = CLEAR;
    int           stub_cnt = 0;
    uint512       digest;
    logic         dv, busy, err;

    int           checks = 0;
    int           failures = 0;
    int           trg_cnt = 0;
    trg_exp_t     exp_trg_q[$];
    logic [511:0] exp_dig_q[$];
    logic [7:0]   msg_q[$];
    trg_exp_t     mon_e;
    logic [511:0] mon_d;
    logic         stall = 1'b0;
    logic         inflight = 1'b0;
    int           c0;

    always #5 clk = ~clk;

    strhw_msg_sequencer #(.STG_TIMEOUT(16'd32)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .mode_i           (mode),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .in_data_i        (in_data),
        .in_bytes_i       (in_bytes),
        .in_last_i        (in_last),
        .stg_trg_o        (stg_trg),
        .stg_block_o      (stg_block),
        .stg_block_size_o (stg_size),
        .stg_h_o          (stg_h),
        .stg_n_o          (stg_n),
        .stg_sigma_o      (stg_sigma),
        .stg_h_new_i      (h_new),
        .stg_n_new_i      (n_new),
        .stg_sigma_new_i  (sigma_new),
        .stg_state_i      (stub_st),
        .digest_o         (digest),
        .digest_valid_o   (dv),
        .busy_o           (busy),
        .err_o            (err)
    );

    // Stub stage: BUSY one cycle after trg, DONE five cycles later, results held
    always @(posedge clk) begin
        if (!rst_ni) begin
            stub_st  <= CLEAR;
            stub_cnt <= 0;
        end else if (stg_trg) begin
            stub_st   <= BUSY;
            stub_cnt  <= 5;
            h_new     <= stg_h ^ stg_block;
            n_new     <= stg_n + 512'({stg_size, 3'b000});
            sigma_new <= stg_sigma + stg_block;
        end else if (stub_st == BUSY) begin
            if (stub_cnt > 1) stub_cnt <= stub_cnt - 1;
            else if (!stall) stub_st <= DONE;
        end
    end

    always @(posedge clk) begin
        if (!rst_ni) inflight <= 1'b0;
        else if (stg_trg) inflight <= 1'b1;
        else if (stub_st == DONE) inflight <= 1'b0;
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: compare every trigger and digest pulse against the queued model results
    always @(negedge clk) begin
        if (rst_ni) begin
            if (stg_trg) begin
                trg_cnt++;
                check("trg_expected", 512'(exp_trg_q.size() != 0), 512'(1));
                if (exp_trg_q.size() != 0) begin
                    mon_e = exp_trg_q.pop_front();
                    check("trg_size", 512'(stg_size), 512'(mon_e.size));
                    check("trg_block", stg_block, mon_e.blk);
                    check("trg_h", stg_h, mon_e.h);
                    check("trg_n", stg_n, mon_e.n);
                    check("trg_sigma", stg_sigma, mon_e.sigma);
                end
                check("trg_ready_low", 512'(in_ready), 512'(0));
            end else if (inflight && !stall) begin
                check("stage_ready_low", 512'(in_ready), 512'(0));
            end
            if (dv) begin
                check("digest_expected", 512'(exp_dig_q.size() != 0), 512'(1));
                if (exp_dig_q.size() != 0) begin
                    mon_d = exp_dig_q.pop_front();
                    check("digest", digest, mon_d);
                end
            end
        end
    end

    task automatic model_msg(input logic md, input logic want_digest);
        logic [511:0] h, n, sigma, blk;
        trg_exp_t e;
        int len, off, sz;
        h = md ? IV_256 : '0;
        n = '0;
        sigma = '0;
        len = msg_q.size();
        off = 0;
        do begin
            sz = (len - off >= 64) ? 64 : len - off;
            blk = '0;
            for (int j = 0; j < sz; j++) blk[j*8 +: 8] = msg_q[off + j];
            e.size = 7'(sz);
            e.blk = blk;
            e.h = h;
            e.n = n;
            e.sigma = sigma;
            exp_trg_q.push_back(e);
            h = h ^ blk;
            n = n + 512'(8 * sz);
            sigma = sigma + blk;
            off += sz;
        end while (sz == 64);
        if (want_digest) exp_dig_q.push_back(md ? {256'h0, h[511:256]} : h);
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [3:0] nb, input logic last,
                              input logic md);
        int waitc = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_bytes = nb;
        in_last  = last;
        mode     = md;
        while (!in_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        check("beat_accept_wait", 512'(waitc < 200), 512'(1));
        @(negedge clk);
    endtask

    // Beats after the first carry the opposite mode, which must be ignored
    task automatic send_msg(input logic md);
        int len, nbeats, cnt;
        logic [63:0] d;
        len = msg_q.size();
        nbeats = (len == 0) ? 1 : (len + 7) / 8;
        for (int b = 0; b < nbeats; b++) begin
            cnt = (b == nbeats - 1) ? len - 8 * b : 8;
            d = {$urandom, $urandom};
            for (int j = 0; j < cnt; j++) d[j*8 +: 8] = msg_q[8*b + j];
            drive_beat(d, 4'(cnt), b == nbeats - 1, (b == 0) ? md : !md);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((exp_dig_q.size() != 0 || busy) && c < 400) begin
            @(negedge clk);
            c++;
        end
        check("idle_wait", 512'(c < 400), 512'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 512'(in_ready), 512'(0));
        check({tag, "_trg"}, 512'(stg_trg), 512'(0));
        check({tag, "_block"}, stg_block, '0);
        check({tag, "_size"}, 512'(stg_size), 512'(0));
        check({tag, "_h"}, stg_h, '0);
        check({tag, "_n"}, stg_n, '0);
        check({tag, "_sigma"}, stg_sigma, '0);
        check({tag, "_digest"}, digest, '0);
        check({tag, "_dv"}, 512'(dv), 512'(0));
        check({tag, "_busy"}, 512'(busy), 512'(0));
        check({tag, "_err"}, 512'(err), 512'(0));
    endtask

    initial begin
        logic [63:0] d0, d1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_ni = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 512'(in_ready), 512'(1));

        // 1: empty message, 512-bit mode
        msg_q.delete();
        model_msg(1'b0, 1'b1);
        send_msg(1'b0);
        wait_idle();

        // 2: 63 bytes k+1, 256-bit mode
        msg_q.delete();
        for (int k = 0; k < 63; k++) msg_q.push_back(8'(k + 1));
        model_msg(1'b1, 1'b1);
        send_msg(1'b1);
        wait_idle();

        // 3: exactly one block -> full block plus size-0 final block
        msg_q.delete();
        for (int k = 0; k < 64; k++) msg_q.push_back(8'($urandom));
        c0 = trg_cnt;
        model_msg(1'b0, 1'b1);
        send_msg(1'b0);
        wait_idle();
        check("t3_trg_pulses", 512'(trg_cnt - c0), 512'(2));

        // 4: 130 bytes back-to-back
        msg_q.delete();
        for (int k = 0; k < 130; k++) msg_q.push_back(8'($urandom));
        c0 = trg_cnt;
        model_msg(1'b0, 1'b1);
        send_msg(1'b0);
        wait_idle();
        check("t4_trg_pulses", 512'(trg_cnt - c0), 512'(3));
        check("t4_n_after", stg_n, 512'(1040));
        check("t4_no_err", 512'(err), 512'(0));

        // 5: reset while the stage is running, then a clean 8-byte message
        msg_q.delete();
        for (int k = 0; k < 16; k++) msg_q.push_back(8'($urandom));
        model_msg(1'b0, 1'b1);
        send_msg(1'b0);
        repeat (3) @(negedge clk);
        rst_ni = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        exp_trg_q.delete();
        exp_dig_q.delete();
        rst_ni = 1'b1;
        @(negedge clk);
        check("ready_after_midreset", 512'(in_ready), 512'(1));
        msg_q.delete();
        for (int k = 0; k < 8; k++) msg_q.push_back(8'($urandom));
        model_msg(1'b1, 1'b1);
        send_msg(1'b1);
        wait_idle();
        check("t5_no_err", 512'(err), 512'(0));

        // 6: short non-last beat flags err; stalled stage times out with no digest
        msg_q.delete();
        for (int k = 0; k < 16; k++) msg_q.push_back(8'($urandom));
        model_msg(1'b0, 1'b0);
        stall = 1'b1;
        for (int j = 0; j < 8; j++) begin
            d0[j*8 +: 8] = msg_q[j];
            d1[j*8 +: 8] = msg_q[8 + j];
        end
        drive_beat(d0, 4'd5, 1'b0, 1'b0);
        check("t6_err_set", 512'(err), 512'(1));
        drive_beat(d1, 4'd8, 1'b1, 1'b0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_idle();
        repeat (10) @(negedge clk);
        check("t6_trg_seen", 512'(exp_trg_q.size()), 512'(0));
        check("t6_err_sticky", 512'(err), 512'(1));
        check("t6_busy_low", 512'(busy), 512'(0));
        check("t6_ready_idle", 512'(in_ready), 512'(1));
        check("t6_dv_low", 512'(dv), 512'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
